// File: rtl/ahb_lite_req_arbiter.sv
// Round-robin arbiter: NUM_REQ requester ports onto one AHB-Lite master, one SINGLE transfer outstanding.
// Optional `ARB_LOCK_EN adds req_lock, which holds the grant on a locking requester and drives HMASTLOCK.
module ahb_lite_req_arbiter #(
    parameter int          NUM_REQ   = 2,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    input  logic [3*NUM_REQ-1:0]   req_size,
    input  logic [32*NUM_REQ-1:0]  req_wdata,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]     req_lock,
`endif
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [31:0]            HADDR,
    output logic                   HWRITE,
    output logic [2:0]             HSIZE,
    output logic [2:0]             HBURST,
    output logic [3:0]             HPROT,
    output logic [1:0]             HTRANS,
    output logic                   HMASTLOCK,
    output logic [31:0]            HWDATA,
    input  logic                   HREADY,
    input  logic                   HRESP,
    input  logic [31:0]            HRDATA,
    output logic [1:0]             dbg_state
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   cand;
    logic            found;
    logic            grant;
    logic            write_q;
    logic [31:0]     addr_q;
    logic [2:0]      size_q;
    logic [31:0]     wdata_q;
    logic            err_q;
    logic            lock_q;

    logic [31:0]     addr_a  [NUM_REQ];
    logic [2:0]      size_a  [NUM_REQ];
    logic [31:0]     wdata_a [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_a[i]  = req_addr[32*i +: 32];
            size_a[i]  = req_size[3*i +: 3];
            wdata_a[i] = req_wdata[32*i +: 32];
        end
    end

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
`ifdef ARB_LOCK_EN
        if (lock_q && req_valid[ptr_q]) winner = ptr_q;
`endif
    end

    // Handshake: req_ready[i] is a combinational one-cycle accept; the request
    // is taken on the clock edge where req_valid[i] && req_ready[i].
    assign grant = HRESETn && (state_q == ST_IDLE) && (|req_valid);

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[winner] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant)  state_d = ST_ADDR;
            ST_ADDR: if (HREADY) state_d = ST_DATA;
            ST_DATA: if (HREADY) state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= PW'(NUM_REQ - 1);
            write_q   <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            lock_q    <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= '0;
            if (grant) begin
                ptr_q   <= winner;
                write_q <= req_write[winner];
                addr_q  <= addr_a[winner];
                size_q  <= size_a[winner];
                wdata_q <= wdata_a[winner];
            end
`ifdef ARB_LOCK_EN
            if (grant)
                lock_q <= req_lock[winner];
            else if (state_q == ST_IDLE)
                lock_q <= 1'b0;
`endif
            // ERROR's first cycle arrives with HREADY low, so it must be remembered.
            if (state_q == ST_DATA) begin
                if (HREADY) begin
                    rsp_valid[ptr_q] <= 1'b1;
                    rsp_err          <= err_q | HRESP;
                    err_q            <= 1'b0;
                    if (!write_q) rsp_rdata <= HRDATA;
                end else if (HRESP) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign HADDR     = addr_q;
    assign HWRITE    = write_q;
    assign HSIZE     = size_q;
    assign HWDATA    = wdata_q;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HTRANS    = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
    assign HMASTLOCK = (state_q == ST_ADDR) && lock_q;
    assign dbg_state = state_q;

endmodule
